// File: rtl/date_span_engine_if.sv
// rtl/date_span_engine_if.sv - request/result bundle between the date-entry front end and date_span_engine.
interface date_span_engine_if #(
  parameter int YEAR_W = 7,
  parameter int DIFF_W = 16
);
  logic              start;
  logic [4:0]        day1;
  logic [3:0]        mon1;
  logic [YEAR_W-1:0] year1;
  logic [4:0]        day2;
  logic [3:0]        mon2;
  logic [YEAR_W-1:0] year2;
  logic              busy;
  logic              done;
  logic [DIFF_W-1:0] day_diff;
  logic [YEAR_W+3:0] mon_diff;
  logic              later;
  logic              err;

  modport master (
    output start, day1, mon1, year1, day2, mon2, year2,
    input  busy, done, day_diff, mon_diff, later, err
  );

  modport slave (
    input  start, day1, mon1, year1, day2, mon2, year2,
    output busy, done, day_diff, mon_diff, later, err
  );
endinterface

// File: rtl/date_span_engine.sv
// rtl/date_span_engine.sv - sequential multi-year calendar distance engine, one year per cycle.
// Leap years are honoured only when LEAP_YEAR_EN is defined; otherwise every year has 365 days.
module date_span_engine #(
  parameter int YEAR_W = 7,
  parameter int DIFF_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  date_span_engine_if.slave bus
);
  localparam int ACC_W = DIFF_W + 1;
  localparam int MON_W = YEAR_W + 4;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP_EN = 1'b1;
`else
  localparam bit LEAP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, CHECK, YEARS, FINAL, DONE} state_t;

  // 2000 is leap; 2100 and 2200 are the only century years reachable with YEAR_W<=8
  function automatic logic is_leap(input logic [YEAR_W-1:0] y);
    return LEAP_EN && ((int'(y) % 4) == 0) && (int'(y) != 100) && (int'(y) != 200);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                    return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      default:                 return 5'd31;
    endcase
  endfunction

  function automatic logic [8:0] days_before(input logic [3:0] m, input logic leap);
    logic [8:0] base;
    case (m)
      4'd2:    base = 9'd31;
      4'd3:    base = 9'd59;
      4'd4:    base = 9'd90;
      4'd5:    base = 9'd120;
      4'd6:    base = 9'd151;
      4'd7:    base = 9'd181;
      4'd8:    base = 9'd212;
      4'd9:    base = 9'd243;
      4'd10:   base = 9'd273;
      4'd11:   base = 9'd304;
      4'd12:   base = 9'd334;
      default: base = 9'd0;
    endcase
    return base + ((leap && (m >= 4'd3)) ? 9'd1 : 9'd0);
  endfunction

  function automatic logic date_ok(input logic [4:0] d, input logic [3:0] m,
                                   input logic [YEAR_W-1:0] y);
    return (m != 4'd0) && (m <= 4'd12) && (d != 5'd0) && (d <= month_len(m, is_leap(y)));
  endfunction

  state_t            state_q, state_d;
  logic [4:0]        d1_q, d1_d, d2_q, d2_d;
  logic [3:0]        m1_q, m1_d, m2_q, m2_d;
  logic [YEAR_W-1:0] y1_q, y1_d, y2_q, y2_d, k_q, k_d;
  logic [ACC_W-1:0]  acc1_q, acc1_d, acc2_q, acc2_d;
  logic [DIFF_W-1:0] day_diff_q, day_diff_d;
  logic [MON_W-1:0]  mon_diff_q, mon_diff_d;
  logic              later_q, later_d, err_q, err_d;

  logic [YEAR_W-1:0] ymax, k_next;
  logic [ACC_W-1:0]  year_len, fin1, fin2;
  logic [MON_W-1:0]  mon1, mon2;

  assign ymax     = (y1_q > y2_q) ? y1_q : y2_q;
  assign k_next   = k_q + YEAR_W'(1);
  assign year_len = is_leap(k_q) ? ACC_W'(366) : ACC_W'(365);
  assign fin1     = acc1_q + ACC_W'(days_before(m1_q, is_leap(y1_q))) + ACC_W'(d1_q) - ACC_W'(1);
  assign fin2     = acc2_q + ACC_W'(days_before(m2_q, is_leap(y2_q))) + ACC_W'(d2_q) - ACC_W'(1);
  assign mon1     = MON_W'(y1_q) * MON_W'(12) + MON_W'(m1_q);
  assign mon2     = MON_W'(y2_q) * MON_W'(12) + MON_W'(m2_q);

  always_comb begin
    state_d    = state_q;
    d1_d       = d1_q;
    d2_d       = d2_q;
    m1_d       = m1_q;
    m2_d       = m2_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    k_d        = k_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    day_diff_d = day_diff_q;
    mon_diff_d = mon_diff_q;
    later_d    = later_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = CHECK;
          d1_d    = bus.day1;
          m1_d    = bus.mon1;
          y1_d    = bus.year1;
          d2_d    = bus.day2;
          m2_d    = bus.mon2;
          y2_d    = bus.year2;
          k_d     = '0;
          acc1_d  = '0;
          acc2_d  = '0;
        end
      end
      CHECK: begin
        if (!date_ok(d1_q, m1_q, y1_q) || !date_ok(d2_q, m2_q, y2_q)) begin
          state_d    = DONE;
          err_d      = 1'b1;
          day_diff_d = '0;
          mon_diff_d = '0;
          later_d    = 1'b0;
        end else if (ymax == '0) begin
          state_d = FINAL;
        end else begin
          state_d = YEARS;
        end
      end
      YEARS: begin
        if (k_q < y1_q) acc1_d = acc1_q + year_len;
        if (k_q < y2_q) acc2_d = acc2_q + year_len;
        k_d = k_next;
        if (k_next == ymax) state_d = FINAL;
      end
      FINAL: begin
        acc1_d     = fin1;
        acc2_d     = fin2;
        day_diff_d = (fin1 > fin2) ? DIFF_W'(fin1 - fin2) : DIFF_W'(fin2 - fin1);
        mon_diff_d = (mon1 > mon2) ? (mon1 - mon2) : (mon2 - mon1);
        later_d    = (fin1 > fin2);
        err_d      = 1'b0;
        state_d    = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d1_q       <= '0;
      d2_q       <= '0;
      m1_q       <= '0;
      m2_q       <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      k_q        <= '0;
      acc1_q     <= '0;
      acc2_q     <= '0;
      day_diff_q <= '0;
      mon_diff_q <= '0;
      later_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d1_q       <= d1_d;
      d2_q       <= d2_d;
      m1_q       <= m1_d;
      m2_q       <= m2_d;
      y1_q       <= y1_d;
      y2_q       <= y2_d;
      k_q        <= k_d;
      acc1_q     <= acc1_d;
      acc2_q     <= acc2_d;
      day_diff_q <= day_diff_d;
      mon_diff_q <= mon_diff_d;
      later_q    <= later_d;
      err_q      <= err_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.day_diff = day_diff_q;
  assign bus.mon_diff = mon_diff_q;
  assign bus.later    = later_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_date_span_engine.sv
// tb/tb_date_span_engine.sv - directed self-checking bench for date_span_engine.
module tb_date_span_engine;
  localparam int YEAR_W = 7;
  localparam int DIFF_W = 16;
`ifdef LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  date_span_engine_if #(.YEAR_W(YEAR_W), .DIFF_W(DIFF_W)) bus ();

  date_span_engine #(.YEAR_W(YEAR_W), .DIFF_W(DIFF_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic set_dates(input int d1, input int m1, input int y1,
                           input int d2, input int m2, input int y2);
    bus.day1  = 5'(d1);
    bus.mon1  = 4'(m1);
    bus.year1 = YEAR_W'(y1);
    bus.day2  = 5'(d2);
    bus.mon2  = 4'(m2);
    bus.year2 = YEAR_W'(y2);
  endtask

  task automatic check_results(input string tag, input int dd, input int md,
                               input bit lt, input bit er);
    check({tag, ".day_diff"}, 32'(bus.day_diff), dd);
    check({tag, ".mon_diff"}, 32'(bus.mon_diff), md);
    check({tag, ".later"}, 32'(bus.later), 32'(lt));
    check({tag, ".err"}, 32'(bus.err), 32'(er));
  endtask

  // Latency counts the start-sampling edge as edge 1; returns with the engine back in IDLE.
  task automatic run(input string tag, input int d1, input int m1, input int y1,
                     input int d2, input int m2, input int y2,
                     input int dd, input int md, input int lat, input bit lt, input bit er);
    int n;
    set_dates(d1, m1, y1, d2, m2, y2);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".latency"}, n, lat);
    check({tag, ".busy_at_done"}, 32'(bus.busy), 1);
    check_results(tag, dd, md, lt, er);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.done), 0);
  endtask

  initial begin
    int n;
    int dones;
    bus.start = 1'b0;
    set_dates(1, 1, 0, 1, 1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 0);
    check("reset.done", 32'(bus.done), 0);
    check_results("reset", 0, 0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run("t2",      15, 3, 24,  1, 3, 24, 14, 0, 27, 1'b1, 1'b0);
    run("t3",       1, 1, 0,   1, 1, 1,  LEAP ? 366 : 365, 12, 4, 1'b0, 1'b0);
    run("t4a",      1, 3, 100, 1, 2, 100, 28, 1, 103, 1'b1, 1'b0);
    run("t4b",      1, 3, 24, 28, 2, 24, LEAP ? 2 : 1, 1, 27, 1'b1, 1'b0);
    run("bad_apr", 31, 4, 5,   1, 1, 0,  0, 0, 2, 1'b0, 1'b1);
    run("bad_feb", 29, 2, 1,   1, 1, 0,  0, 0, 2, 1'b0, 1'b1);
    run("bad_mon",  1, 1, 0,   1, 13, 0, 0, 0, 2, 1'b0, 1'b1);
    run("feb29",   29, 2, 4,   1, 3, 4,  LEAP ? 1 : 0, LEAP ? 1 : 0, LEAP ? 7 : 2, 1'b0, !LEAP);
    run("equal",    5, 6, 7,   5, 6, 7,  0, 0, 10, 1'b0, 1'b0);
    run("yearend",  1, 1, 0,  31, 12, 0, LEAP ? 365 : 364, 11, 3, 1'b0, 1'b0);
    run("multi",    1, 1, 5,   1, 1, 0,  LEAP ? 1827 : 1825, 60, 8, 1'b1, 1'b0);
    run("century",  1, 1, 101, 1, 1, 99, 730, 24, 104, 1'b1, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("hold.busy", 32'(bus.busy), 0);
    check_results("hold", 730, 24, 1'b1, 1'b0);

    // second start while busy must not disturb the first request
    set_dates(15, 3, 24, 1, 3, 24);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 1;
    repeat (4) begin
      @(posedge clk); #1;
      n++;
    end
    set_dates(1, 1, 0, 1, 1, 1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n++;
    while (bus.done !== 1'b1 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("ignore.latency", n, 27);
    check_results("ignore", 14, 0, 1'b1, 1'b0);
    @(posedge clk); #1;

    // start held high: each run is 4 edges plus one IDLE cycle
    set_dates(1, 1, 0, 1, 1, 1);
    bus.start = 1'b1;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done === 1'b1) begin
        dones++;
        check("b2b.day_diff", 32'(bus.day_diff), LEAP ? 366 : 365);
      end
    end
    bus.start = 1'b0;
    check("b2b.count", dones, 4);
    @(posedge clk); #1;

    // asynchronous reset in the middle of YEARS
    set_dates(1, 1, 50, 1, 1, 0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("rst.busy_before", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.done", 32'(bus.done), 0);
    check_results("rst", 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("rst.busy_held", 32'(bus.busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("post_rst", 1, 1, 0, 1, 1, 1, LEAP ? 366 : 365, 12, 4, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
